l2_cache_control: RTL and testbench

- Control FSM that sequences the 2-way, 8-set, 32-byte-line L2 cache datapath.
- Sits between the L1/arbiter side (mem_*) and physical memory (pmem_*).
- Drives every array read/load strobe, the data-in and address muxes, and the per-way byte enables.
- Implements hit service, dirty-victim writeback, line fill and LRU update.

---
 rtl/l2_cache_pkg.sv | 7 +
 rtl/l2_perf_counters.sv | 23 ++
 rtl/l2_cache_control.sv | 190 +++++++++++++++++++
 tb/tb_l2_cache_control.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// Shared types and constants for the 2-way, 8-set, 32-byte-line L2 cache controller.
package l2_cache_pkg;
  typedef enum logic [2:0] {IDLE, CHECK, WRITEBACK, FETCH, RELOAD} l2_state_t;
  localparam int          LINE_BYTES = 32;
  localparam logic [31:0] BE_ALL     = 32'hFFFF_FFFF;
  typedef logic way_t;
endpackage

// File: rtl/l2_perf_counters.sv
// Hit / miss / writeback event counters; wrap modulo 2**32, synchronous clear.
module l2_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_hit_inc,
  input  logic        i_miss_inc,
  input  logic        i_wb_inc,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count,
  output logic [31:0] o_wb_count
);
  always_ff @(posedge clk) begin
    if (rst) begin
      o_hit_count  <= '0;
      o_miss_count <= '0;
      o_wb_count   <= '0;
    end else begin
      if (i_hit_inc)  o_hit_count  <= o_hit_count  + 32'd1;
      if (i_miss_inc) o_miss_count <= o_miss_count + 32'd1;
      if (i_wb_inc)   o_wb_count   <= o_wb_count   + 32'd1;
    end
  end
endmodule

// File: rtl/l2_cache_control.sv
// L2 cache control FSM: hit service, dirty-victim writeback, line fill, LRU update.
// Optional performance counters are built when L2_PERF_CTR_EN is defined.
module l2_cache_control
  import l2_cache_pkg::*;
#(
  parameter int s_offset = 5,
  parameter int s_index  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [2**s_offset-1:0]   mem_byte_enable256,
  output logic                     mem_resp,
  output logic                     pmem_read,
  output logic                     pmem_write,
  input  logic                     pmem_resp,
  input  logic                     hit0,
  input  logic                     hit1,
  input  logic                     lru_out,
  input  logic                     dirty0_out,
  input  logic                     dirty1_out,
  input  logic                     valid0_out,
  input  logic                     valid1_out,
  output logic [2**s_offset-1:0]   byte_enable0,
  output logic [2**s_offset-1:0]   byte_enable1,
  output logic                     lru_in,
  output logic                     dirty0_in,
  output logic                     dirty1_in,
  output logic                     valid0_in,
  output logic                     valid1_in,
  output logic                     ld_lru,
  output logic                     ld_dirty0,
  output logic                     ld_dirty1,
  output logic                     ld_valid0,
  output logic                     ld_valid1,
  output logic                     ld_tag0,
  output logic                     ld_tag1,
  output logic                     rd_data0,
  output logic                     rd_data1,
  output logic                     rd_dirty0,
  output logic                     rd_dirty1,
  output logic                     rd_valid0,
  output logic                     rd_valid1,
  output logic                     rd_lru,
  output logic                     rd_tag0,
  output logic                     rd_tag1,
  output logic                     datain0_sel,
  output logic                     datain1_sel,
  output logic                     mem_addr_sel,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count,
  output logic [31:0]              wb_count
);
  if (2**s_offset != LINE_BYTES || s_index < 1) begin : g_cfg_chk
    $error("l2_cache_control: unsupported cache geometry");
  end

  l2_state_t r_state, w_next;
  way_t      w_victim, w_hit_way;
  logic      w_req, w_hit, w_vic_dirty;

  assign w_req       = mem_read | mem_write;
  assign w_hit       = hit0 | hit1;
  assign w_hit_way   = way_t'(~hit0);
  assign w_victim    = way_t'(lru_out);
  assign w_vic_dirty = w_victim ? (valid1_out & dirty1_out) : (valid0_out & dirty0_out);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    mem_resp     = 1'b0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    byte_enable0 = '0;
    byte_enable1 = '0;
    lru_in       = 1'b0;
    dirty0_in    = 1'b0;
    dirty1_in    = 1'b0;
    valid0_in    = 1'b0;
    valid1_in    = 1'b0;
    ld_lru       = 1'b0;
    ld_dirty0    = 1'b0;
    ld_dirty1    = 1'b0;
    ld_valid0    = 1'b0;
    ld_valid1    = 1'b0;
    ld_tag0      = 1'b0;
    ld_tag1      = 1'b0;
    rd_data0     = 1'b0;
    rd_data1     = 1'b0;
    rd_dirty0    = 1'b0;
    rd_dirty1    = 1'b0;
    rd_valid0    = 1'b0;
    rd_valid1    = 1'b0;
    rd_lru       = 1'b0;
    rd_tag0      = 1'b0;
    rd_tag1      = 1'b0;
    datain0_sel  = 1'b0;
    datain1_sel  = 1'b0;
    mem_addr_sel = 1'b0;
    // Reset masks every strobe so an in-flight pmem transfer is dropped at once.
    if (!rst) begin
      unique case (r_state)
        IDLE, RELOAD: begin
          {rd_data0, rd_data1, rd_dirty0, rd_dirty1, rd_valid0, rd_valid1} = '1;
          {rd_lru, rd_tag0, rd_tag1} = '1;
          if (r_state == RELOAD) w_next = CHECK;
          else if (w_req)        w_next = CHECK;
        end
        CHECK: begin
          if (!w_req) begin
            w_next = IDLE;
          end else if (w_hit) begin
            mem_resp = 1'b1;
            ld_lru   = 1'b1;
            lru_in   = ~w_hit_way;
            if (mem_write) begin
              if (w_hit_way) begin
                byte_enable1 = mem_byte_enable256;
                ld_dirty1    = 1'b1;
                dirty1_in    = 1'b1;
              end else begin
                byte_enable0 = mem_byte_enable256;
                ld_dirty0    = 1'b1;
                dirty0_in    = 1'b1;
              end
            end
            w_next = IDLE;
          end else begin
            w_next = w_vic_dirty ? WRITEBACK : FETCH;
          end
        end
        WRITEBACK: begin
          mem_addr_sel = 1'b1;
          pmem_write   = 1'b1;
          if (pmem_resp) begin
            if (w_victim) ld_dirty1 = 1'b1;
            else          ld_dirty0 = 1'b1;
            w_next = FETCH;
          end
        end
        FETCH: begin
          pmem_read = 1'b1;
          if (w_victim) datain1_sel = 1'b1;
          else          datain0_sel = 1'b1;
          if (pmem_resp) begin
            if (w_victim) begin
              byte_enable1 = BE_ALL;
              {ld_tag1, ld_valid1, valid1_in, ld_dirty1} = '1;
            end else begin
              byte_enable0 = BE_ALL;
              {ld_tag0, ld_valid0, valid0_in, ld_dirty0} = '1;
            end
            w_next = RELOAD;
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

`ifdef L2_PERF_CTR_EN
  // The forced hit after a fill belongs to the miss, so it is not counted.
  logic r_refill;
  always_ff @(posedge clk) begin
    if (rst)                     r_refill <= 1'b0;
    else if (r_state == RELOAD)  r_refill <= 1'b1;
    else if (r_state == IDLE)    r_refill <= 1'b0;
  end

  l2_perf_counters u_perf (
    .clk          (clk),
    .rst          (rst),
    .i_hit_inc    (mem_resp & ~r_refill),
    .i_miss_inc   ((r_state == CHECK) && (w_next == WRITEBACK || w_next == FETCH)),
    .i_wb_inc     ((r_state == WRITEBACK) && pmem_resp && !rst),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count),
    .o_wb_count   (wb_count)
  );
`else
  assign hit_count  = '0;
  assign miss_count = '0;
  assign wb_count   = '0;
`endif
endmodule

// File: tb/tb_l2_cache_control.sv
// Randomized bench for l2_cache_control: emulated tag/valid/dirty/LRU arrays driven by
// the DUT strobes, checked against a per-set line model updated from the cache rules.
module tb_l2_cache_control;
  import l2_cache_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        mem_read = 0, mem_write = 0, pmem_resp = 0;
  logic [31:0] mem_byte_enable256 = '0;
  logic        hit0 = 0, hit1 = 0, lru_out = 0, dirty0_out = 0, dirty1_out = 0;
  logic        valid0_out = 0, valid1_out = 0;
  logic        mem_resp, pmem_read, pmem_write;
  logic [31:0] byte_enable0, byte_enable1, hit_count, miss_count, wb_count;
  logic        lru_in, dirty0_in, dirty1_in, valid0_in, valid1_in;
  logic        ld_lru, ld_dirty0, ld_dirty1, ld_valid0, ld_valid1, ld_tag0, ld_tag1;
  logic        rd_data0, rd_data1, rd_dirty0, rd_dirty1, rd_valid0, rd_valid1, rd_lru;
  logic        rd_tag0, rd_tag1, datain0_sel, datain1_sel, mem_addr_sel;

  always #5 clk = ~clk;

  l2_cache_control dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable256(mem_byte_enable256), .mem_resp(mem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
    .hit0(hit0), .hit1(hit1), .lru_out(lru_out), .dirty0_out(dirty0_out),
    .dirty1_out(dirty1_out), .valid0_out(valid0_out), .valid1_out(valid1_out),
    .byte_enable0(byte_enable0), .byte_enable1(byte_enable1), .lru_in(lru_in),
    .dirty0_in(dirty0_in), .dirty1_in(dirty1_in), .valid0_in(valid0_in), .valid1_in(valid1_in),
    .ld_lru(ld_lru), .ld_dirty0(ld_dirty0), .ld_dirty1(ld_dirty1), .ld_valid0(ld_valid0),
    .ld_valid1(ld_valid1), .ld_tag0(ld_tag0), .ld_tag1(ld_tag1),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .rd_dirty0(rd_dirty0), .rd_dirty1(rd_dirty1),
    .rd_valid0(rd_valid0), .rd_valid1(rd_valid1), .rd_lru(rd_lru), .rd_tag0(rd_tag0),
    .rd_tag1(rd_tag1), .datain0_sel(datain0_sel), .datain1_sel(datain1_sel),
    .mem_addr_sel(mem_addr_sel), .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
  );

  int n_vec = 0, n_err = 0;
  int m_hit = 0, m_miss = 0, m_wb = 0;

  // dp_*: datapath arrays written only by DUT strobes; rf_*: reference line state.
  logic [7:0] dp_tag [8][2];
  bit         dp_valid [8][2], dp_dirty [8][2], dp_lru [8];
  logic [7:0] rf_tag [8][2];
  bit         rf_valid [8][2], rf_dirty [8][2], rf_lru [8];
  int         cur_set = 0;
  logic [7:0] cur_tag = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic dp_outs();
    hit0       = dp_valid[cur_set][0] && (dp_tag[cur_set][0] == cur_tag);
    hit1       = dp_valid[cur_set][1] && (dp_tag[cur_set][1] == cur_tag);
    lru_out    = dp_lru[cur_set];
    valid0_out = dp_valid[cur_set][0];
    valid1_out = dp_valid[cur_set][1];
    dirty0_out = dp_dirty[cur_set][0];
    dirty1_out = dp_dirty[cur_set][1];
  endtask

  function automatic logic [31:0] dp_pack(input int s);
    return {11'd0, dp_tag[s][1], dp_tag[s][0], dp_valid[s][1], dp_valid[s][0],
            dp_dirty[s][1], dp_dirty[s][0], dp_lru[s]};
  endfunction

  function automatic logic [31:0] rf_pack(input int s);
    return {11'd0, rf_tag[s][1], rf_tag[s][0], rf_valid[s][1], rf_valid[s][0],
            rf_dirty[s][1], rf_dirty[s][0], rf_lru[s]};
  endfunction

  // One upstream request; lw/lr = cycles pmem_write/pmem_read stay high incl. the resp cycle.
  task automatic do_req(input bit wr, input int s, input logic [7:0] t,
                        input logic [31:0] be, input int lw, input int lr);
    int  hw, v, exp_cyc, cyc, pcnt;
    bit  hit, wb, done, saw_wb, saw_fill, resp_now;
    bit  l_tag0, l_tag1, l_v0, l_v1, l_d0, l_d1, l_lru, v0i, v1i, d0i, d1i, li;
    hit = 0; hw = 0; v = 0; wb = 0;
    for (int w = 0; w < 2; w++)
      if (rf_valid[s][w] && rf_tag[s][w] == t) begin hit = 1; hw = w; end
    if (hit) begin
      exp_cyc = 1;
      m_hit++;
    end else begin
      v  = int'(rf_lru[s]);
      wb = rf_valid[s][v] && rf_dirty[s][v];
      exp_cyc = (wb ? lw : 0) + lr + 3;
      m_miss++;
      if (wb) m_wb++;
      rf_tag[s][v] = t; rf_valid[s][v] = 1; rf_dirty[s][v] = 0;
      hw = v;
    end
    rf_lru[s] = (hw == 0);
    if (wr) rf_dirty[s][hw] = 1;

    cur_set = s; cur_tag = t; dp_outs();
    mem_read = !wr; mem_write = wr; mem_byte_enable256 = be;
    cyc = 0; pcnt = 0; done = 0; saw_wb = 0; saw_fill = 0;
    while (!done) begin
      @(negedge clk);
      if (pmem_read || pmem_write) begin
        pcnt++;
        pmem_resp = (pcnt == (pmem_write ? lw : lr));
      end else pmem_resp = 1'b0;
      #1;
      resp_now = pmem_resp;
      if (pmem_write) begin
        saw_wb = 1;
        if (pmem_resp) chk("wb_addr_sel", 32'(mem_addr_sel), 32'd1);
      end
      if (pmem_read && pmem_resp) begin
        saw_fill = 1;
        chk("fill_addr_sel", 32'(mem_addr_sel), 32'd0);
        chk("fill_be_victim", v ? byte_enable1 : byte_enable0, BE_ALL);
        chk("fill_be_other", v ? byte_enable0 : byte_enable1, 32'd0);
      end
      if (mem_resp) begin
        chk("resp_cycle", 32'(cyc), 32'(exp_cyc));
        chk("lru_in", 32'(lru_in), 32'(hw == 0));
        if (wr) chk("wr_hit_be", hw ? byte_enable1 : byte_enable0, be);
        done = 1;
      end
      {l_tag0, l_tag1, l_v0, l_v1, l_d0, l_d1, l_lru} =
        {ld_tag0, ld_tag1, ld_valid0, ld_valid1, ld_dirty0, ld_dirty1, ld_lru};
      {v0i, v1i, d0i, d1i, li} = {valid0_in, valid1_in, dirty0_in, dirty1_in, lru_in};
      @(posedge clk); #1;
      if (l_tag0) dp_tag[s][0] = t;
      if (l_tag1) dp_tag[s][1] = t;
      if (l_v0)   dp_valid[s][0] = v0i;
      if (l_v1)   dp_valid[s][1] = v1i;
      if (l_d0)   dp_dirty[s][0] = d0i;
      if (l_d1)   dp_dirty[s][1] = d1i;
      if (l_lru)  dp_lru[s] = li;
      if (resp_now) begin pmem_resp = 1'b0; pcnt = 0; end
      if (done) begin mem_read = 0; mem_write = 0; end
      dp_outs();
      cyc++;
      if (!done && cyc > 200) begin
        chk("resp_timeout", 32'(cyc), 32'(exp_cyc));
        mem_read = 0; mem_write = 0; done = 1;
      end
    end
    chk("wb_seen", 32'(saw_wb), 32'(wb));
    chk("fill_seen", 32'(saw_fill), 32'(!hit));
    chk("set_state", dp_pack(s), rf_pack(s));
  endtask

  task automatic chk_ctrs(input string tag);
`ifdef L2_PERF_CTR_EN
    chk({tag, "_hit"},  hit_count,  32'(m_hit));
    chk({tag, "_miss"}, miss_count, 32'(m_miss));
    chk({tag, "_wb"},   wb_count,   32'(m_wb));
`else
    chk({tag, "_hit"},  hit_count,  32'd0);
    chk({tag, "_miss"}, miss_count, 32'd0);
    chk({tag, "_wb"},   wb_count,   32'd0);
`endif
  endtask

  initial begin
    int k;
    for (int s = 0; s < 8; s++) begin
      dp_lru[s] = 0; rf_lru[s] = 0;
      for (int w = 0; w < 2; w++) begin
        dp_tag[s][w] = '0; dp_valid[s][w] = 0; dp_dirty[s][w] = 0;
        rf_tag[s][w] = '0; rf_valid[s][w] = 0; rf_dirty[s][w] = 0;
      end
    end
    dp_outs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_resp", 32'(mem_resp), 32'd0);
    chk("rst_pmem", 32'({pmem_read, pmem_write}), 32'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_rd_tag0", 32'(rd_tag0), 32'd1);

    @(posedge clk); #1;
    do_req(0, 0, 8'h01, 32'h0, 5, 5);          // cold read, fill way 0
    do_req(0, 0, 8'h01, 32'h0, 5, 5);          // read hit
    do_req(1, 0, 8'h01, 32'h0000_000F, 3, 3);  // write hit, way 0 dirty
    do_req(0, 0, 8'h02, 32'h0, 3, 4);          // fill way 1
    do_req(0, 0, 8'h03, 32'h0, 4, 5);          // dirty way 0 victim: writeback then fill
    chk_ctrs("ctr_directed");

    for (int i = 0; i < 60; i++)
      do_req(1'($urandom_range(0, 1)), $urandom_range(0, 3), 8'($urandom_range(0, 3)),
             $urandom, $urandom_range(1, 6), $urandom_range(1, 6));
    chk_ctrs("ctr_random");

    // Reset mid-FETCH on an empty set: transfer must drop, arrays untouched.
    cur_set = 7; cur_tag = 8'hAA; dp_outs();
    mem_read = 1;
    k = 0;
    while (!pmem_read && k < 20) begin @(negedge clk); #1; k++; end
    chk("reach_fetch", 32'(pmem_read), 32'd1);
    @(posedge clk); #1 rst = 1'b1; mem_read = 0;
    @(negedge clk); #1;
    chk("rst_fetch_pmem_read", 32'(pmem_read), 32'd0);
    chk("rst_fetch_ld", 32'({ld_tag0, ld_tag1, ld_valid0, ld_valid1, ld_dirty0, ld_dirty1, ld_lru}), 32'd0);
    @(negedge clk);
    chk("rst_ctr_hit", hit_count, 32'd0);
    chk("rst_ctr_miss", miss_count, 32'd0);
    chk("rst_ctr_wb", wb_count, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(rd_lru), 32'd1);
    chk("post_rst_pmem", 32'({pmem_read, pmem_write, mem_resp}), 32'd0);
    chk("post_rst_set7", dp_pack(7), rf_pack(7));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
